// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   WORD_W        instruction word width used by the core
//   MAGIC_DEFAULT default frame start byte
//   state_e       loader FSM state encoding
package imem_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles accepted bytes into little-endian 32-bit words.
//   clk, reset   clock, asynchronous active-high reset
//   clear        drop any partially assembled word
//   byte_valid   byte_data is accepted this cycle
//   byte_data    incoming byte
//   at_last      the next accepted byte completes a word
//   word         last completed word {b3,b2,b1,b0}; holds until the next one
//   word_valid   one-cycle pulse, the cycle after the completing byte
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              at_last,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        cnt_q;
  logic [WORD_W-9:0] shreg_q;  // first three bytes, newest at the top
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;

  assign at_last    = (cnt_q == 2'd3);
  assign word       = word_q;
  assign word_valid = word_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_valid && at_last;
      if (clear) begin
        cnt_q   <= '0;
        shreg_q <= '0;
      end else if (byte_valid) begin
        cnt_q <= cnt_q + 2'd1;
        if (at_last) begin
          word_q <= {byte_data, shreg_q};
        end else begin
          shreg_q <= {byte_data, shreg_q[WORD_W-9:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory and holds the core in
// reset until a frame with a good checksum has been written.
// Frame: MAGIC, LEN_LO, LEN_HI, 4*LEN payload bytes, CSUM (xor of payload).
//   clk, reset   clock, asynchronous active-high reset
//   in_valid     byte stream valid
//   in_data      byte stream data
//   in_ready     always 1; a byte is taken on every in_valid cycle
//   mem_we       one-cycle write strobe, one cycle after the word's last byte
//   mem_addr     word address of the write; holds after mem_we drops
//   mem_wdata    assembled word
//   cpu_hold     core held in reset unless the last frame loaded cleanly
//   done         last frame loaded with a good checksum
//   error        last frame failed its length or checksum check
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter logic [7:0]  MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic [7:0]        acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic        pk_clear;
  logic        pk_valid;
  logic        pk_last;
  logic [15:0] len_full;

  assign in_ready = 1'b1;
  assign mem_addr = addr_q;
  assign done     = (state_q == StDone);
  assign error    = (state_q == StErr);
  assign cpu_hold = (state_q != StDone);
  assign len_full = {in_data, len_q[7:0]};

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .at_last    (pk_last),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    widx_d   = widx_q;
    acc_d    = acc_q;
    addr_d   = addr_q;
    pk_clear = 1'b0;
    pk_valid = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (in_data == MAGIC) begin
            state_d  = StLen0;
            widx_d   = '0;
            acc_d    = '0;
            pk_clear = 1'b1;
          end
        end
        StLen0: begin
          len_d[7:0] = in_data;
          state_d    = StLen1;
        end
        StLen1: begin
          len_d[15:8] = in_data;
          if (32'(len_full) > DEPTH) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          pk_valid = 1'b1;
          acc_d    = acc_q ^ in_data;
          if (pk_last) begin
            // Address lines up with the packer's word_valid on the next cycle.
            addr_d = widx_q[ADDR_W-1:0];
            widx_d = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) begin
              state_d = StCsum;
            end
          end
        end
        StCsum: begin
          state_d = (in_data == acc_q) ? StDone : StErr;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      widx_q  <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, bad checksum, length limits,
// stalls, mid-frame reset and reload.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  frm[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled between edges.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns at a falling edge; byte is taken at the rising edge between.
  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (frm[i]) send(frm[i], gap);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_log(input string tag, input int n, input logic [31:0] w0,
                           input logic [31:0] w1);
    check({tag, " nwrites"}, wr_addr.size(), n);
    if (n > 0 && wr_addr.size() > 0) begin
      check({tag, " addr0"}, {24'h0, wr_addr[0]}, 32'd0);
      check({tag, " data0"}, wr_data[0], w0);
    end
    if (n > 1 && wr_addr.size() > 1) begin
      check({tag, " addr1"}, {24'h0, wr_addr[1]}, 32'd1);
      check({tag, " data1"}, wr_data[1], w1);
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    check("rst in_ready", {31'h0, in_ready}, 32'd1);
    check("rst mem_we", {31'h0, mem_we}, 32'd0);
    check("rst mem_addr", {24'h0, mem_addr}, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst cpu_hold", {31'h0, cpu_hold}, 32'd1);
    check("rst done", {31'h0, done}, 32'd0);
    check("rst error", {31'h0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: two words; checksum 13^B3^50 = F0.
    clear_log();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
    send_frame(0);
    idle(2);
    check_log("s1", 2, 32'h0000_0013, 32'h0050_00B3);
    check("s1 done", {31'h0, done}, 32'd1);
    check("s1 error", {31'h0, error}, 32'd0);
    check("s1 cpu_hold", {31'h0, cpu_hold}, 32'd0);
    check("s1 mem_addr held", {24'h0, mem_addr}, 32'd1);

    // 2: same frame, bad checksum.
    clear_log();
    frm[11] = 8'h00;
    send_frame(0);
    idle(2);
    check_log("s2", 2, 32'h0000_0013, 32'h0050_00B3);
    check("s2 error", {31'h0, error}, 32'd1);
    check("s2 done", {31'h0, done}, 32'd0);
    check("s2 cpu_hold", {31'h0, cpu_hold}, 32'd1);

    // 3: empty frame, then an over-long length.
    clear_log();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("s3 empty done", {31'h0, done}, 32'd1);
    check("s3 empty cpu_hold", {31'h0, cpu_hold}, 32'd0);
    frm = '{8'hA5, 8'h01, 8'h01};
    send_frame(0);
    check("s3 len257 error", {31'h0, error}, 32'd1);
    check("s3 len257 done", {31'h0, done}, 32'd0);
    idle(2);
    check_log("s3", 0, 32'h0, 32'h0);

    // Boundary: len=256 is accepted (moves on to payload, not ERR).
    frm = '{8'hA5, 8'h00, 8'h01};
    send_frame(0);
    check("s3 len256 error", {31'h0, error}, 32'd0);
    // Back to a known ERR state with a bad checksum on an empty frame.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frm = '{8'hA5, 8'h00, 8'h00, 8'h77};
    send_frame(0);
    check("s3 empty badcs error", {31'h0, error}, 32'd1);

    // 4: junk ignored, stalled payload.
    clear_log();
    send(8'h11, 0);
    send(8'h22, 0);
    check("s4 junk error kept", {31'h0, error}, 32'd1);
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
    send_frame(1);
    idle(2);
    check_log("s4", 2, 32'h0000_0013, 32'h0050_00B3);
    check("s4 done", {31'h0, done}, 32'd1);

    // 5: reset after six payload bytes, then a clean reload.
    clear_log();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00};
    send_frame(0);
    check("s5 mid cpu_hold", {31'h0, cpu_hold}, 32'd1);
    reset = 1'b1;
    #1;
    check("s5 rst mem_wdata", mem_wdata, 32'd0);
    check("s5 rst mem_addr", {24'h0, mem_addr}, 32'd0);
    check("s5 rst cpu_hold", {31'h0, cpu_hold}, 32'd1);
    check("s5 rst done", {31'h0, done}, 32'd0);
    check("s5 rst error", {31'h0, error}, 32'd0);
    check("s5 rst mem_we", {31'h0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
    send_frame(0);
    idle(2);
    check_log("s5", 2, 32'h0000_0013, 32'h0050_00B3);
    check("s5 done", {31'h0, done}, 32'd1);

    // 6: reload one word after DONE; an A5 inside the payload is plain data.
    // Checksum EF^A5^AD^DE = 39.
    clear_log();
    send(8'hA5, 0);
    check("s6 magic cpu_hold", {31'h0, cpu_hold}, 32'd1);
    check("s6 magic done", {31'h0, done}, 32'd0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hEF, 0);
    send(8'hA5, 0);
    send(8'hAD, 0);
    send(8'hDE, 0);
    check("s6 pre-csum cpu_hold", {31'h0, cpu_hold}, 32'd1);
    send(8'h39, 0);
    check("s6 cpu_hold", {31'h0, cpu_hold}, 32'd0);
    check("s6 done", {31'h0, done}, 32'd1);
    idle(2);
    check_log("s6", 1, 32'hDEAD_A5EF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
